// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: STAGES chained slices, each a main register plus a
// one-deep skid, so upstream ready is always registered and never sees out_ready.
module pipe_stage_reg #(
    parameter int               WIDTH     = 32,
    parameter int               STAGES    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] occupancy
);

    logic [STAGES-1:0] main_valid;
    logic [STAGES-1:0] slice_ready;
    logic [WIDTH-1:0]  main_data [STAGES];

    // Holds in_ready low until the first edge that samples rst high.
    logic             run_reg;
    logic [CNT_W-1:0] occ_reg;
    logic             in_accept;
    logic             out_consume;

    always_ff @(posedge clk) begin
        run_reg <= rst;
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_slice
        logic             main_valid_reg;
        logic             skid_valid_reg;
        logic [WIDTH-1:0] main_data_reg;
        logic [WIDTH-1:0] skid_data_reg;
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             down_ready;
        logic             accept;
        logic             consume;

        if (gi == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_body
            assign up_valid = main_valid[gi-1];
            assign up_data  = main_data[gi-1];
        end

        if (gi == STAGES - 1) begin : g_tail
            assign down_ready = out_ready;
        end else begin : g_link
            assign down_ready = slice_ready[gi+1];
        end

        assign slice_ready[gi] = ~skid_valid_reg & ((gi != 0) | run_reg);
        assign accept          = up_valid & slice_ready[gi];
        assign consume         = main_valid_reg & down_ready;
        assign main_valid[gi]  = main_valid_reg;
        assign main_data[gi]   = main_data_reg;

        always_ff @(posedge clk) begin
            if (!rst || flush) begin
                main_valid_reg <= 1'b0;
                skid_valid_reg <= 1'b0;
                main_data_reg  <= RESET_VAL;
                skid_data_reg  <= RESET_VAL;
            end else if (!main_valid_reg || consume) begin
                // accept is impossible while the skid is full, so the skid drains first
                if (skid_valid_reg) begin
                    main_valid_reg <= 1'b1;
                    main_data_reg  <= skid_data_reg;
                    skid_valid_reg <= 1'b0;
                end else if (accept) begin
                    main_valid_reg <= 1'b1;
                    main_data_reg  <= up_data;
                end else begin
                    main_valid_reg <= 1'b0;
                end
            end else if (accept) begin
                skid_valid_reg <= 1'b1;
                skid_data_reg  <= up_data;
            end
        end
    end

    assign in_ready    = slice_ready[0];
    assign out_valid   = main_valid[STAGES-1];
    assign out_data    = main_data[STAGES-1];
    assign in_accept   = in_valid & in_ready;
    assign out_consume = out_valid & out_ready;

    // Internal slice-to-slice moves conserve beats, so only the ends change the count.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_reg + CNT_W'(in_accept) - CNT_W'(out_consume);
        end
    end

    assign occupancy = occ_reg;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised elastic pipeline register that replaces the fixed-width, always-enabled stage latch between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Each slice carries a payload with valid/ready handshaking and a 2-entry skid buffer, so stalls propagate upstream one registered cycle late without losing data. A synchronous flush inserts bubbles for branch/jump squash. Depth is configurable, so one instance can span several pipeline slices.

Parameters:
WIDTH, 32, payload width in bits
STAGES, 1, number of chained slices (1..8)
RESET_VAL, 0, payload value loaded on reset/flush (bubble content, e.g. NOP encoding)
CNT_W, 5, width of occupancy output; must satisfy 2^CNT_W > 2*STAGES

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low
flush  in  1  squash all held beats at next edge
in_valid  in  1  upstream beat present
in_ready  out  1  block can accept a beat this cycle
in_data  in  WIDTH  upstream payload
out_valid  out  1  beat present at output
out_ready  in  1  downstream accepts beat this cycle
out_data  out  WIDTH  output payload
occupancy  out  CNT_W  number of valid beats held across all slices

Behaviour:
- Reset: rst sampled low at an edge -> every slice main_valid=0, skid_valid=0, main/skid data=RESET_VAL. While rst is low: in_ready=0, out_valid=0, out_data=RESET_VAL, occupancy=0. in_ready=1 on the first cycle after rst is sampled high.
- Priority at an edge: rst > flush > normal handshake.
- Transfer: input accepted iff in_valid & in_ready; output consumed iff out_valid & out_ready. Slice k output feeds slice k+1 input with the same rules internally.
- Per-slice registers: main (valid, data), skid (valid, data). Slice in_ready = ~skid_valid (registered, no combinational path from out_ready to in_ready).
- Slice update, same edge:
  - main empty or main consumed: main loads from skid if skid_valid, else from input if accepted, else becomes empty; skid clears when it was drained.
  - main full and not consumed, input accepted: input goes to skid (skid_valid=1).
  - Never drop or duplicate a beat; order is strictly FIFO.
- out_valid/out_data come from the last slice's main register. in_ready comes from the first slice.
- Latency: beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. visible in cycle N+STAGES, when no stall. Throughput: 1 beat/cycle sustained with out_ready held high.
- Stall: out_ready low -> output holds data stable while out_valid=1. in_ready falls no earlier than one cycle after the stall reaches slice 0's skid. Capacity before backpressure is 2*STAGES beats.
- Flush: at the edge it is sampled high, all valid bits clear and all data regs load RESET_VAL. A beat offered on the same cycle is discarded even if in_ready=1. A beat consumed on the same cycle (out_valid & out_ready) still counts as delivered. occupancy=0 the next cycle.
- occupancy = sum of all main_valid + skid_valid bits, registered with the state. Increments on accept, decrements on consume, unchanged when both happen. Never exceeds 2*STAGES.
- Data stability: out_data only changes when out_valid=0 or a consume occurred at the prior edge.
- X-safety: in_data is ignored when in_valid=0. No register captures it.

Test Plan:
1. STAGES=1, rst low 2 cycles then high; in_valid=1 streaming 0x1,0x2,0x3, out_ready=1 -> out_data 0x1,0x2,0x3 on consecutive cycles starting 1 cycle after first accept; occupancy stays 1.
2. STAGES=3, stream 0xA0..0xA9 with out_ready=1 -> first out_valid 3 cycles after first accept, 10 beats in order, no gaps.
3. STAGES=2, out_ready=0, in_valid=1 continuous with 0x10,0x11,... -> exactly 4 beats accepted, in_ready=0, occupancy=4. Then out_ready=1 -> 0x10..0x13 emerge in order, then streaming resumes.
4. STAGES=2, 3 beats held with out_ready=0; pulse flush with in_valid=1, in_data=0xFF -> next cycle out_valid=0, occupancy=0, out_data=RESET_VAL. 0xFF never appears at the output.
5. Randomised out_ready toggling (50%) with STAGES=4, 200 beats numbered 0..199 -> scoreboard shows every beat exactly once, in order. occupancy always equals accepted minus consumed.
6. rst driven low mid-stream with 5 beats held -> after one edge out_valid=0, in_ready=0, occupancy=0. After release the first new beat 0x55 arrives with normal latency.
